acs_layer: RTL and testbench
============================

ACS_LAYER -- requirements
Module: acs_layer

Interface
REQ-001 Parameter K, default 7: constraint length; NUM_STATES = 2^(K-1); legal range 3..9.
REQ-002 Parameter POLY_A, default 7'b1001111 (0x4F): generator polynomial A, K bits.
REQ-003 Parameter POLY_B, default 7'b1101101 (0x6D): generator polynomial B, K bits.
REQ-004 Parameter BM_WIDTH, default 8: branch metric width, unsigned.
REQ-005 Parameter SM_WIDTH, default 12: state metric width, unsigned; SM_MAX = 2^SM_WIDTH-1.
REQ-006 Parameter NORM_THRESH, default 2^(SM_WIDTH-1): normalization threshold, less than SM_MAX.
REQ-007 clk  input  1  rising-edge clock; the only clock.
REQ-008 sys_rst_n  input  1  reset; synchronous, active-low.
REQ-009 start  input  1  frame start: reinitialize all state metrics.
REQ-010 valid_in  input  1  one trellis step is presented this cycle.
REQ-011 bm_00, bm_01, bm_10, bm_11  input  BM_WIDTH each  branch metric for encoder output pair {a,b}.
REQ-012 decisions  output  NUM_STATES  survivor decision bit per new state.
REQ-013 valid_out  output  1  decisions and norm_flag are valid.
REQ-014 norm_flag  output  1  normalization was applied in this step.
REQ-015 best_state  output  K-1  index of the minimum stored metric.
REQ-016 best_metric  output  SM_WIDTH  value of that minimum.
REQ-017 best_valid  output  1  best_state and best_metric are valid.

Function
REQ-018 Trellis: next state ns = ((p<<1)|u) mod NUM_STATES; predecessors p0 = ns>>1 and p1 = (ns>>1) + NUM_STATES/2; u = ns[0].
REQ-019 Encoder word r = (p<<1)|u as K bits; a = XOR-reduce(r & POLY_A), b = XOR-reduce(r & POLY_B); the selected branch metric is bm_{ab}.
REQ-020 Path metric pm = sm[p] + bm, computed at SM_WIDTH+1 bits; the result saturates to SM_MAX if it exceeds SM_MAX, or if sm[p] == SM_MAX.
REQ-021 Select the lower path metric; a tie selects p0; decisions[ns] = 1 iff p1 is selected.
REQ-022 All NUM_STATES ACS operations complete in one step; the new metrics are written to the metric register on the same clock edge.
REQ-023 Latency: decisions, norm_flag and valid_out are registered, and valid_out is high exactly 1 cycle after each valid_in; it is a single-cycle pulse with no backpressure.
REQ-024 Normalization: if the minimum of the stored metrics is at least NORM_THRESH when valid_in is sampled, subtract NORM_THRESH from every selected metric below SM_MAX; SM_MAX entries stay SM_MAX; norm_flag = 1 for that step.
REQ-025 Best-state search is combinational over the stored metrics and is registered; best_valid pulses 1 cycle after valid_out; ties resolve to the lowest index.
REQ-026 start without valid_in: next cycle sm[0] = 0 and all other sm = SM_MAX; no valid_out is produced.
REQ-027 start with valid_in in the same cycle: the ACS step operates on the initialized metrics (sm[0] = 0, others SM_MAX), not on the stored ones.
REQ-028 Back-to-back valid_in on consecutive cycles is supported at full rate, one step per cycle.
REQ-029 When valid_in is low, the metrics, decisions, norm_flag, best_state and best_metric hold their values.

Reset
REQ-030 While sys_rst_n is low at a clock edge: valid_out = 0, best_valid = 0, norm_flag = 0, decisions = 0, best_state = 0, best_metric = 0, sm[0] = 0, all other sm = SM_MAX.
REQ-031 Reset mid-stream discards any in-flight step; no valid_out or best_valid is emitted for a step that was accepted in the cycle before reset.
REQ-032 Reset takes priority over start and valid_in.

Verification (K=3, POLY_A=3'b111, POLY_B=3'b101, BM_WIDTH=4, SM_WIDTH=8, NORM_THRESH=128)
REQ-033 Reset, then valid_in with bm_00=0 and bm_01=bm_10=bm_11=4 -> next cycle valid_out=1, decisions=4'b0000, sm={0,4,255,255}; following cycle best_valid=1, best_state=0, best_metric=0.
REQ-034 Encode bit sequence 1,0,1,1,0,0 with ideal metrics (0 on the matching pair, 15 otherwise) -> best_metric stays 0 every step, and the traceback of decisions reproduces the input bits.
REQ-035 Preload metrics to near SM_MAX by repeatedly applying all bm=15 -> no metric exceeds 255, SM_MAX entries persist, there is no wrap-around, and the comparison remains monotonic.
REQ-036 Drive min sm ≥ 128 -> the step pulses norm_flag=1, every non-saturated metric is reduced by exactly 128, and decisions equal those of an unnormalized reference model.
REQ-037 start with valid_in on the same cycle as a mid-stream step -> the result equals the REQ-033 result; start alone -> no valid_out, and the next best_state=0, best_metric=0.
REQ-038 Assert sys_rst_n low on the cycle after valid_in -> valid_out=0 and best_valid=0 in all following cycles, and the metrics return to {0,255,255,255}.

Source files
------------

// File: rtl/acs_layer.sv
// Add-compare-select layer of a Viterbi decoder: one full trellis step per valid_in,
// with saturating state metrics, threshold normalization and a registered best-state search.
module acs_layer #(
    parameter int             K           = 7,
    parameter logic [K-1:0]   POLY_A      = 7'b1001111,
    parameter logic [K-1:0]   POLY_B      = 7'b1101101,
    parameter int             BM_WIDTH    = 8,
    parameter int             SM_WIDTH    = 12,
    parameter int             NORM_THRESH = 2 ** (SM_WIDTH - 1)
) (
    input  logic                    clk,
    input  logic                    sys_rst_n,
    input  logic                    start,
    input  logic                    valid_in,
    input  logic [BM_WIDTH-1:0]     bm_00,
    input  logic [BM_WIDTH-1:0]     bm_01,
    input  logic [BM_WIDTH-1:0]     bm_10,
    input  logic [BM_WIDTH-1:0]     bm_11,
    output logic [2**(K-1)-1:0]     decisions,
    output logic                    valid_out,
    output logic                    norm_flag,
    output logic [K-2:0]            best_state,
    output logic [SM_WIDTH-1:0]     best_metric,
    output logic                    best_valid
);
    localparam int NS = 2 ** (K - 1);
    localparam logic [SM_WIDTH-1:0] SM_MAX = '1;
    localparam logic [SM_WIDTH-1:0] THRESH = SM_WIDTH'(NORM_THRESH);

    // Handshake: valid_in is accepted every cycle it is high (no ready); valid_out pulses one
    // cycle later, best_valid one cycle after valid_out. Neither output can be stalled.

    logic [SM_WIDTH-1:0] sm      [NS];
    logic [SM_WIDTH-1:0] sm_src  [NS];
    logic [SM_WIDTH-1:0] sm_next [NS];
    logic [SM_WIDTH-1:0] pm0     [NS];
    logic [SM_WIDTH-1:0] pm1     [NS];
    logic [SM_WIDTH-1:0] sel     [NS];
    logic [NS-1:0]       dec_next;
    logic [SM_WIDTH-1:0] min_src;
    logic                norm;
    logic [K-2:0]        best_idx;
    logic [SM_WIDTH-1:0] best_val;

    function automatic logic [BM_WIDTH-1:0] pick_bm(
        input logic [K-1:0]        r,
        input logic [BM_WIDTH-1:0] b00,
        input logic [BM_WIDTH-1:0] b01,
        input logic [BM_WIDTH-1:0] b10,
        input logic [BM_WIDTH-1:0] b11
    );
        logic a;
        logic b;
        a = ^(r & POLY_A);
        b = ^(r & POLY_B);
        case ({a, b})
            2'b00:   return b00;
            2'b01:   return b01;
            2'b10:   return b10;
            default: return b11;
        endcase
    endfunction

    // A saturated metric marks an unreachable state and must never become reachable again.
    function automatic logic [SM_WIDTH-1:0] add_sat(
        input logic [SM_WIDTH-1:0] s,
        input logic [BM_WIDTH-1:0] b
    );
        logic [SM_WIDTH:0] sum;
        sum = {1'b0, s} + (SM_WIDTH + 1)'(b);
        if (s == SM_MAX || sum > {1'b0, SM_MAX}) return SM_MAX;
        return sum[SM_WIDTH-1:0];
    endfunction

    // start with valid_in runs the step on freshly initialized metrics.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            sm_src[i] = start ? ((i == 0) ? '0 : SM_MAX) : sm[i];
        end
        min_src = sm_src[0];
        for (int i = 1; i < NS; i++) begin
            if (sm_src[i] < min_src) min_src = sm_src[i];
        end
        norm = (min_src >= THRESH);
    end

    // The encoder word for predecessor p0 equals ns; p1 only adds the top bit.
    always_comb begin
        dec_next = '0;
        for (int i = 0; i < NS; i++) begin
            pm0[i] = add_sat(sm_src[i / 2], pick_bm(K'(i), bm_00, bm_01, bm_10, bm_11));
            pm1[i] = add_sat(sm_src[i / 2 + NS / 2], pick_bm(K'(i + NS), bm_00, bm_01, bm_10, bm_11));
            if (pm1[i] < pm0[i]) begin
                dec_next[i] = 1'b1;
                sel[i]      = pm1[i];
            end else begin
                sel[i]      = pm0[i];
            end
            sm_next[i] = (norm && sel[i] != SM_MAX) ? sel[i] - THRESH : sel[i];
        end
    end

    always_comb begin
        best_idx = '0;
        best_val = sm[0];
        for (int i = 1; i < NS; i++) begin
            if (sm[i] < best_val) begin
                best_val = sm[i];
                best_idx = (K - 1)'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NS; i++) sm[i] <= (i == 0) ? '0 : SM_MAX;
            decisions   <= '0;
            valid_out   <= 1'b0;
            norm_flag   <= 1'b0;
            best_state  <= '0;
            best_metric <= '0;
            best_valid  <= 1'b0;
        end else begin
            valid_out  <= valid_in;
            best_valid <= valid_out;
            if (valid_in) begin
                for (int i = 0; i < NS; i++) sm[i] <= sm_next[i];
                decisions <= dec_next;
                norm_flag <= norm;
            end else if (start) begin
                for (int i = 0; i < NS; i++) sm[i] <= sm_src[i];
            end
            if (valid_out) begin
                best_state  <= best_idx;
                best_metric <= best_val;
            end
        end
    end
endmodule

// File: tb/tb_acs_layer.sv
// Bench for acs_layer at K=3: directed and random trellis steps checked against a
// plain-arithmetic Viterbi metric model, including saturation, normalization, start and reset.
module tb_acs_layer;
    localparam int K   = 3;
    localparam int NS  = 4;
    localparam int MAX = 255;
    localparam int NT  = 128;

    logic           clk = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic           start = 1'b0;
    logic           valid_in = 1'b0;
    logic [3:0]     bm_00 = '0, bm_01 = '0, bm_10 = '0, bm_11 = '0;
    logic [NS-1:0]  decisions;
    logic           valid_out, norm_flag, best_valid;
    logic [K-2:0]   best_state;
    logic [7:0]     best_metric;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    int m_sm[NS];
    int m_dec, m_norm, m_vo, m_bv, m_bs, m_bm;

    int dec_hist[6];
    int in_bits[6] = '{1, 0, 1, 1, 0, 0};

    acs_layer #(
        .K(3), .POLY_A(3'b111), .POLY_B(3'b101),
        .BM_WIDTH(4), .SM_WIDTH(8), .NORM_THRESH(128)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .valid_in(valid_in),
        .bm_00(bm_00), .bm_01(bm_01), .bm_10(bm_10), .bm_11(bm_11),
        .decisions(decisions), .valid_out(valid_out), .norm_flag(norm_flag),
        .best_state(best_state), .best_metric(best_metric), .best_valid(best_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output pair of a rate-1/2 encoder for the K-bit word r, polys 111 / 101.
    function automatic int pair_of(input int r);
        int a, b;
        a = $countones(r & 7) % 2;
        b = $countones(r & 5) % 2;
        return a * 2 + b;
    endfunction

    function automatic int path(input int s, input int b);
        if (s == MAX) return MAX;
        return (s + b > MAX) ? MAX : s + b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_sm[i] = (i == 0) ? 0 : MAX;
        m_dec = 0; m_norm = 0; m_vo = 0; m_bv = 0; m_bs = 0; m_bm = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_out"}, 32'(valid_out), m_vo);
        chk({tag, ".best_valid"}, 32'(best_valid), m_bv);
        chk({tag, ".decisions"}, 32'(decisions), m_dec);
        chk({tag, ".norm_flag"}, 32'(norm_flag), m_norm);
        chk({tag, ".best_state"}, 32'(best_state), m_bs);
        chk({tag, ".best_metric"}, 32'(best_metric), m_bm);
        for (int i = 0; i < NS; i++) chk($sformatf("%s.sm%0d", tag, i), 32'(dut.sm[i]), m_sm[i]);
    endtask

    // One clock cycle: drive inputs, advance the model, then compare everything.
    task automatic cycle(input string tag, input bit v, input bit st,
                         input int b00, input int b01, input int b10, input int b11);
        int src[NS];
        int nsm[NS];
        int bms[4];
        int mn, p0, p1, c0, c1, u, pick;
        @(negedge clk);
        valid_in = v; start = st;
        bm_00 = 4'(b00); bm_01 = 4'(b01); bm_10 = 4'(b10); bm_11 = 4'(b11);
        bms = '{b00, b01, b10, b11};
        if (m_vo != 0) begin
            m_bs = 0; m_bm = m_sm[0];
            for (int i = 1; i < NS; i++) if (m_sm[i] < m_bm) begin m_bm = m_sm[i]; m_bs = i; end
        end
        for (int i = 0; i < NS; i++) src[i] = st ? ((i == 0) ? 0 : MAX) : m_sm[i];
        if (v) begin
            mn = src[0];
            for (int i = 1; i < NS; i++) if (src[i] < mn) mn = src[i];
            m_norm = (mn >= NT) ? 1 : 0;
            m_dec = 0;
            for (int ns = 0; ns < NS; ns++) begin
                u  = ns % 2;
                p0 = ns / 2;
                p1 = p0 + NS / 2;
                c0 = path(src[p0], bms[pair_of((p0 * 2 + u) % 8)]);
                c1 = path(src[p1], bms[pair_of((p1 * 2 + u) % 8)]);
                if (c1 < c0) begin pick = c1; m_dec += (1 << ns); end
                else pick = c0;
                if (m_norm != 0 && pick != MAX) pick -= NT;
                nsm[ns] = pick;
            end
            m_sm = nsm;
        end else if (st) begin
            m_sm = src;
        end
        m_bv = m_vo;
        m_vo = v ? 1 : 0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        sys_rst_n = 1'b0; valid_in = 1'b1; start = 1'b1;
        bm_00 = 4'($urandom_range(15)); bm_01 = 4'($urandom_range(15));
        bm_10 = 4'($urandom_range(15)); bm_11 = 4'($urandom_range(15));
        model_reset();
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
        sys_rst_n = 1'b1; valid_in = 1'b0; start = 1'b0;
    endtask

    initial begin
        int st, r, pr, s, traced, expect_bits;
        int bm[4];
        model_reset();
        repeat (2) @(posedge clk);
        do_reset("reset");

        // single step from reset with bm_00=0, others 4
        cycle("basic_step", 1, 0, 0, 4, 4, 4);
        chk("basic_dec", 32'(decisions), 0);
        chk("basic_sm1", 32'(dut.sm[1]), 4);
        cycle("basic_best", 0, 0, 0, 0, 0, 0);
        chk("basic_best_metric", 32'(best_metric), 0);

        // ideal-channel encode of 1,0,1,1,0,0 and traceback
        do_reset("reset2");
        st = 0;
        for (int t = 0; t < 6; t++) begin
            r = st * 2 + in_bits[t];
            pr = pair_of(r);
            for (int j = 0; j < 4; j++) bm[j] = (j == pr) ? 0 : 15;
            cycle($sformatf("enc%0d", t), 1, 0, bm[0], bm[1], bm[2], bm[3]);
            dec_hist[t] = 32'(decisions);
            if (t > 0) chk($sformatf("enc_best_metric%0d", t), 32'(best_metric), 0);
            st = r % NS;
        end
        cycle("enc_tail", 0, 0, 0, 0, 0, 0);
        chk("enc_final_metric", 32'(best_metric), 0);
        chk("enc_final_state", 32'(best_state), st);
        s = best_state;
        traced = 0; expect_bits = 0;
        for (int t = 5; t >= 0; t--) begin
            traced |= (s % 2) << t;
            expect_bits |= in_bits[t] << t;
            s = s / 2 + (((dec_hist[t] >> s) & 1) != 0 ? NS / 2 : 0);
        end
        chk("traceback_bits", traced, expect_bits);

        // saturation and normalization: all-15 branch metrics drive metrics upward
        do_reset("reset3");
        for (int t = 0; t < 14; t++) cycle($sformatf("sat%0d", t), 1, 0, 15, 15, 15, 15);
        for (int t = 0; t < 20; t++)
            cycle($sformatf("hi%0d", t), 1, 0, $urandom_range(8, 15), $urandom_range(8, 15),
                  $urandom_range(8, 15), $urandom_range(8, 15));

        // random traffic with idles and occasional start
        for (int t = 0; t < 60; t++)
            cycle($sformatf("rnd%0d", t), ($urandom_range(3) != 0), ($urandom_range(9) == 0),
                  $urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));

        // start with valid_in mid-stream, then start alone
        cycle("mid_pre", 1, 0, 9, 2, 7, 3);
        cycle("mid_start", 1, 1, 0, 4, 4, 4);
        chk("mid_start_dec", 32'(decisions), 0);
        chk("mid_start_sm1", 32'(dut.sm[1]), 4);
        cycle("mid_best", 0, 0, 0, 0, 0, 0);
        chk("mid_best_state", 32'(best_state), 0);
        cycle("warm", 1, 0, 5, 1, 3, 2);
        cycle("start_only", 0, 1, 0, 0, 0, 0);
        chk("start_only_vo", 32'(valid_out), 0);
        cycle("after_start", 1, 0, 0, 4, 4, 4);
        cycle("after_start_best", 0, 0, 0, 0, 0, 0);
        chk("after_start_best_metric", 32'(best_metric), 0);

        // reset right after an accepted step
        cycle("pre_reset", 1, 0, 3, 6, 1, 2);
        do_reset("reset_mid");
        for (int t = 0; t < 3; t++) cycle($sformatf("post_reset%0d", t), 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
